// File: rtl/noc_outport_alloc_if.sv
// Request/grant bundle between input controllers and one output allocator.
// The slave side is the allocator; the master side is the requester side.
interface noc_outport_alloc_if #(
  parameter int PORT_N = 5,
  parameter int PORT_W = 3,
  parameter int TYPE_W = 3
);
  logic [PORT_N-1:0]        req;
  logic [PORT_N*TYPE_W-1:0] in_type;
  logic                     out_fire;
  logic [PORT_N-1:0]        grt;
  logic [PORT_W-1:0]        grt_idx;
  logic                     lck;
  logic                     err;

  modport master (
    output req, in_type, out_fire,
    input  grt, grt_idx, lck, err
  );

  modport slave (
    input  req, in_type, out_fire,
    output grt, grt_idx, lck, err
  );
endinterface

// File: rtl/noc_outport_alloc.sv
// Per-output-port wormhole switch allocator: round-robin grant,
// held from HEAD until the TAIL/HEADTAIL flit leaves the port.
module noc_outport_alloc #(
  parameter int PORT_N = 5,
  parameter int PORT_W = 3,
  parameter int TYPE_W = 3
) (
  input logic              clk,
  input logic              rst,
  noc_outport_alloc_if.slave bus
);
  localparam logic [TYPE_W-1:0] T_HEAD = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_TAIL = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_HT   = TYPE_W'(3);
  localparam logic [PORT_W:0]   NUM    = (PORT_W+1)'(PORT_N);
  localparam logic [PORT_W-1:0] LAST   = PORT_W'(PORT_N-1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [PORT_N-1:0]   grt_q, grt_d;
  logic [PORT_W-1:0]   idx_q, idx_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic                err_q, err_d;

  logic [TYPE_W-1:0]   typ [PORT_N];
  logic [PORT_N-1:0]   elig;
  logic [PORT_N-1:0]   bad;
  logic [PORT_W-1:0]   sel;
  logic [PORT_W:0]     cand;
  logic                found;
  logic [TYPE_W-1:0]   cur_type;
  logic                tail_fire;

  for (genvar i = 0; i < PORT_N; i++) begin : g_in
    logic is_head;
    assign typ[i]  = bus.in_type[i*TYPE_W +: TYPE_W];
    assign is_head = (typ[i] == T_HEAD) | (typ[i] == T_HT);
    assign elig[i] = bus.req[i] & is_head;
    assign bad[i]  = bus.req[i] & ~is_head;
  end

  // Scan ptr, ptr+1, ... with modulo-PORT_N wrap (non power of two).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < PORT_N; k++) begin
      cand = {1'b0, ptr_q} + (PORT_W+1)'(k);
      if (cand >= NUM) cand = cand - NUM;
      if (!found && elig[cand[PORT_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[PORT_W-1:0];
      end
    end
  end

  assign cur_type  = typ[idx_q];
  assign tail_fire = bus.out_fire &
                     ((cur_type == T_TAIL) | (cur_type == T_HT));

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = bus.out_fire | (|bad);
        grt_d = '0;
        idx_d = '0;
        if (found) begin
          state_d = LOCKED;
          grt_d   = PORT_N'(1) << sel;
          idx_d   = sel;
        end
      end
      LOCKED: begin
        if (tail_fire) begin
          state_d = IDLE;
          grt_d   = '0;
          idx_d   = '0;
          ptr_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.grt     = grt_q;
  assign bus.grt_idx = idx_q;
  assign bus.lck     = (state_q == LOCKED);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_noc_outport_alloc.sv
// Scenario bench for noc_outport_alloc; expected grants are
// queued when requests are driven and popped when grants appear.
module tb_noc_outport_alloc;
  localparam int PORT_N = 5;
  localparam int PORT_W = 3;
  localparam int TYPE_W = 3;
  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_HEAD = 3'd1;
  localparam logic [2:0] T_TAIL = 3'd2;
  localparam logic [2:0] T_HT   = 3'd3;
  localparam logic [2:0] T_DATA = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_outport_alloc_if #(
    .PORT_N(PORT_N), .PORT_W(PORT_W), .TYPE_W(TYPE_W)
  ) bus ();

  noc_outport_alloc #(
    .PORT_N(PORT_N), .PORT_W(PORT_W), .TYPE_W(TYPE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [PORT_N-1:0] grt_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_type(input int i, input logic [2:0] t);
    bus.in_type[i*TYPE_W +: TYPE_W] = t;
  endtask

  task automatic clear_in;
    bus.req      = '0;
    bus.in_type  = '0;
    bus.out_fire = 1'b0;
  endtask

  task automatic do_reset;
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.grt !== 5'b0) begin
      errors++;
      $display("FAIL rst_grt: got %b want 00000", bus.grt);
    end
    checks++;
    if (bus.grt_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_idx: got %0d want 0", bus.grt_idx);
    end
    checks++;
    if (bus.lck !== 1'b0) begin
      errors++;
      $display("FAIL rst_lck: got %b want 0", bus.lck);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: got %b want 0", bus.err);
    end
  endtask

  task automatic test_single_headtail;
    do_reset();
    bus.req = 5'b00100;
    set_type(2, T_HT);
    tick();
    checks++;
    if (bus.grt !== 5'b00100) begin
      errors++;
      $display("FAIL ht_grt: got %b want 00100", bus.grt);
    end
    checks++;
    if (bus.grt_idx !== 3'd2) begin
      errors++;
      $display("FAIL ht_idx: got %0d want 2", bus.grt_idx);
    end
    checks++;
    if (bus.lck !== 1'b1) begin
      errors++;
      $display("FAIL ht_lck: got %b want 1", bus.lck);
    end
    bus.out_fire = 1'b1;
    tick();
    checks++;
    if (bus.grt !== 5'b0 || bus.lck !== 1'b0) begin
      errors++;
      $display("FAIL ht_rel: got grt=%b lck=%b want 00000/0",
               bus.grt, bus.lck);
    end
    clear_in();
    bus.req = 5'b11111;
    for (int i = 0; i < PORT_N; i++) set_type(i, T_HEAD);
    exp_q.push_back(3);
    tick();
    checks++;
    if (bus.grt_idx !== 3'(exp_q.pop_front())) begin
      errors++;
      $display("FAIL ht_ptr: got %0d want 3", bus.grt_idx);
    end
  endtask

  task automatic test_fairness;
    int pos[PORT_N];
    logic prev_lck;
    logic fired;
    int g_prev, lock_len, idle_len, grants, e;
    bit done;
    do_reset();
    foreach (pos[i]) pos[i] = 0;
    prev_lck = 1'b0;
    fired = 1'b0;
    g_prev = 0;
    lock_len = 0;
    idle_len = 0;
    grants = 0;
    done = 1'b0;
    bus.req = 5'b11111;
    for (int i = 0; i < PORT_N; i++) set_type(i, T_HEAD);
    exp_q = {0, 1, 2, 3, 4, 0, 1};
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      if (fired) pos[g_prev] = (pos[g_prev] + 1) % 3;
      checks++;
      if (bus.err !== 1'b0) begin
        errors++;
        $display("FAIL fair_err: got %b want 0", bus.err);
      end
      if (bus.lck && !prev_lck) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fair_extra: got idx %0d want none",
                   bus.grt_idx);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.grt_idx !== 3'(e)) begin
            errors++;
            $display("FAIL fair_order: got %0d want %0d",
                     bus.grt_idx, e);
          end
          checks++;
          if (bus.grt !== (5'b1 << e)) begin
            errors++;
            $display("FAIL fair_onehot: got %b want %b",
                     bus.grt, 5'b1 << e);
          end
        end
        if (grants > 0) begin
          checks++;
          if (idle_len != 1) begin
            errors++;
            $display("FAIL fair_bubble: got %0d want 1", idle_len);
          end
        end
        grants++;
        lock_len = 0;
        idle_len = 0;
      end
      if (!bus.lck && prev_lck) begin
        checks++;
        if (lock_len != 3) begin
          errors++;
          $display("FAIL fair_len: got %0d want 3", lock_len);
        end
      end
      if (bus.lck) lock_len++;
      else begin
        idle_len++;
        checks++;
        if (bus.grt !== 5'b0) begin
          errors++;
          $display("FAIL fair_idle_grt: got %b want 00000", bus.grt);
        end
      end
      prev_lck = bus.lck;
      if (grants == 7 && !bus.lck) begin
        done = 1'b1;
        break;
      end
      fired = bus.lck;
      g_prev = int'(bus.grt_idx);
      bus.out_fire = bus.lck;
      for (int i = 0; i < PORT_N; i++)
        set_type(i, pos[i] == 0 ? T_HEAD :
                    pos[i] == 1 ? T_DATA : T_TAIL);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fair_timeout: got %0d grants want 7", grants);
    end
    exp_q.delete();
    clear_in();
  endtask

  task automatic test_lock_hold;
    logic [PORT_N-1:0] eg;
    do_reset();
    bus.req = 5'b00010;
    set_type(1, T_HEAD);
    grt_q.push_back(5'b00010);
    for (int c = 2; c <= 11; c++) begin
      tick();
      eg = grt_q.pop_front();
      checks++;
      if (bus.grt !== eg) begin
        errors++;
        $display("FAIL hold_c%0d: got %b want %b", c, bus.grt, eg);
      end
      bus.req[0] = 1'b1;
      set_type(0, T_HEAD);
      bus.req[1] = (c <= 9);
      set_type(1, c == 2 ? T_HEAD :
                  c <= 7 ? T_DATA :
                  c <= 9 ? T_TAIL : T_NONE);
      bus.out_fire = (c == 2 || c == 4 || c == 7 || c == 9);
      if (c < 11)
        grt_q.push_back(c + 1 <= 9  ? 5'b00010 :
                        c + 1 == 10 ? 5'b00000 : 5'b00001);
    end
    clear_in();
  endtask

  task automatic test_pointer;
    do_reset();
    bus.req = 5'b01000;
    set_type(3, T_HT);
    tick();
    checks++;
    if (bus.grt_idx !== 3'd3) begin
      errors++;
      $display("FAIL ptr_first: got %0d want 3", bus.grt_idx);
    end
    bus.out_fire = 1'b1;
    tick();
    clear_in();
    bus.req = 5'b10001;
    set_type(4, T_HEAD);
    set_type(0, T_HEAD);
    exp_q.push_back(4);
    tick();
    checks++;
    if (bus.grt_idx !== 3'(exp_q.pop_front())) begin
      errors++;
      $display("FAIL ptr_wrap: got %0d want 4", bus.grt_idx);
    end
    set_type(4, T_TAIL);
    bus.out_fire = 1'b1;
    tick();
    checks++;
    if (bus.lck !== 1'b0) begin
      errors++;
      $display("FAIL ptr_rel: got %b want 0", bus.lck);
    end
    clear_in();
    bus.req = 5'b00001;
    set_type(0, T_HEAD);
    exp_q.push_back(0);
    tick();
    checks++;
    if (bus.grt_idx !== 3'(exp_q.pop_front()) || bus.lck !== 1'b1) begin
      errors++;
      $display("FAIL ptr_next: got idx=%0d lck=%b want 0/1",
               bus.grt_idx, bus.lck);
    end
    clear_in();
  endtask

  task automatic test_errors;
    do_reset();
    bus.req = 5'b01000;
    set_type(3, T_DATA);
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.grt !== 5'b0) begin
      errors++;
      $display("FAIL err_data: got err=%b grt=%b want 1/00000",
               bus.err, bus.grt);
    end
    clear_in();
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got %b want 0", bus.err);
    end
    bus.out_fire = 1'b1;
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.lck !== 1'b0) begin
      errors++;
      $display("FAIL err_fire: got err=%b lck=%b want 1/0",
               bus.err, bus.lck);
    end
    clear_in();
    bus.req = 5'b01010;
    set_type(3, T_DATA);
    set_type(1, T_HEAD);
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.grt !== 5'b00010) begin
      errors++;
      $display("FAIL err_mixed: got err=%b grt=%b want 1/00010",
               bus.err, bus.grt);
    end
    clear_in();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req = 5'b00100;
    set_type(2, T_HEAD);
    tick();
    checks++;
    if (bus.lck !== 1'b1 || bus.grt_idx !== 3'd2) begin
      errors++;
      $display("FAIL mid_lock: got lck=%b idx=%0d want 1/2",
               bus.lck, bus.grt_idx);
    end
    bus.out_fire = 1'b1;
    set_type(2, T_DATA);
    tick();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.grt !== 5'b0 || bus.lck !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got grt=%b lck=%b err=%b want 0/0/0",
               bus.grt, bus.lck, bus.err);
    end
    bus.req = 5'b10000;
    set_type(4, T_HEAD);
    tick();
    checks++;
    if (bus.grt !== 5'b10000 || bus.grt_idx !== 3'd4) begin
      errors++;
      $display("FAIL mid_regrant: got grt=%b idx=%0d want 10000/4",
               bus.grt, bus.grt_idx);
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_headtail();
    test_fairness();
    test_lock_hold();
    test_pointer();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
